alu_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one combinational signed ALU between NREQ requesters. The ALU is a 3-bit two's-complement unit with operations add/sub/AND/OR and an overflow output. The scheduler picks one pending requester, latches its operands and opcode, and drives them to the ALU. It then captures the ALU result and overflow and returns them with a one-cycle valid pulse tagged with the requester ID. It sits between the switch/requester front end and the ALU that feeds the SEG/LED decode.

---
 rtl/alu_rr_scheduler_if.sv | 47 ++++
 rtl/alu_rr_scheduler.sv | 144 ++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_rr_scheduler_if.sv
// Bundle of requester, ALU and response signals for alu_rr_scheduler.
// slave: the scheduler's view. master: the requester/ALU side.
// Optional macro ALU_OVF_STICKY_EN adds the ovf_sticky / ovf_clr pair.
interface alu_rr_scheduler_if #(
    parameter int NREQ  = 2,
    parameter int NBITS = 3
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*NBITS-1:0] req_a;
    logic [NREQ*NBITS-1:0] req_b;
    logic [NREQ*2-1:0]     req_f;
    logic [NREQ-1:0]       gnt;
    logic [NBITS-1:0]      alu_a;
    logic [NBITS-1:0]      alu_b;
    logic [1:0]            alu_f;
    logic [NBITS-1:0]      alu_y;
    logic                  alu_ovf;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [NBITS-1:0]      rsp_y;
    logic                  rsp_ovf;
    logic                  busy;
`ifdef ALU_OVF_STICKY_EN
    logic [NREQ-1:0]       ovf_sticky;
    logic [NREQ-1:0]       ovf_clr;

    modport slave (
        input  req, req_a, req_b, req_f, alu_y, alu_ovf, ovf_clr,
        output gnt, alu_a, alu_b, alu_f, rsp_valid, rsp_id, rsp_y, rsp_ovf, busy, ovf_sticky
    );
    modport master (
        output req, req_a, req_b, req_f, alu_y, alu_ovf, ovf_clr,
        input  gnt, alu_a, alu_b, alu_f, rsp_valid, rsp_id, rsp_y, rsp_ovf, busy, ovf_sticky
    );
`else
    modport slave (
        input  req, req_a, req_b, req_f, alu_y, alu_ovf,
        output gnt, alu_a, alu_b, alu_f, rsp_valid, rsp_id, rsp_y, rsp_ovf, busy
    );
    modport master (
        output req, req_a, req_b, req_f, alu_y, alu_ovf,
        input  gnt, alu_a, alu_b, alu_f, rsp_valid, rsp_id, rsp_y, rsp_ovf, busy
    );
`endif
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one combinational signed ALU between NREQ
// requesters. One operation per IDLE -> EXEC -> RESP pass, no pipelining.
// Optional macro ALU_OVF_STICKY_EN: per-requester sticky overflow flags.
//
// state | meaning
// IDLE  | waiting; arbitrates and latches the winner's operands
// EXEC  | grant pulse; ALU settles on the latched operands
// RESP  | rsp_valid pulse with the captured result
module alu_rr_scheduler #(
    parameter int NREQ  = 2,
    parameter int NBITS = 3
) (
    input logic            clk_2,
    input logic            reset,
    alu_rr_scheduler_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           state, state_nxt;
    logic             grant_en;
    logic             capture_en;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   winner;
    logic             cap_ovf;

    logic [NREQ-1:0]  gnt_q;
    logic [NBITS-1:0] alu_a_q;
    logic [NBITS-1:0] alu_b_q;
    logic [1:0]       alu_f_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [NBITS-1:0] rsp_y_q;
    logic             rsp_ovf_q;

    // First pending requester after ptr, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] pick_winner(input logic [NREQ-1:0] r,
                                                   input logic [IDW-1:0]  ptr);
        logic [IDW-1:0] w;
        logic           found;
        int             idx;
        w     = ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && r[IDW'(idx)]) begin
                w     = IDW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign winner = pick_winner(bus.req, rr_ptr);

    // Logic ops never report overflow, whatever the ALU flag says.
    assign cap_ovf = alu_f_q[1] ? 1'b0 : bus.alu_ovf;

    // State register.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_nxt  = state;
        grant_en   = 1'b0;
        capture_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (|bus.req) begin
                    grant_en  = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                capture_en = 1'b1;
                state_nxt  = S_RESP;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch on grant, result capture at the end of EXEC.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            gnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_f_q     <= '0;
            rr_ptr      <= IDW'(NREQ - 1);
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            if (grant_en) begin
                alu_a_q <= bus.req_a[int'(winner)*NBITS +: NBITS];
                alu_b_q <= bus.req_b[int'(winner)*NBITS +: NBITS];
                alu_f_q <= bus.req_f[int'(winner)*2 +: 2];
                gnt_q   <= NREQ'(1) << winner;
                rr_ptr  <= winner;
            end
            if (capture_en) begin
                rsp_y_q     <= bus.alu_y;
                rsp_id_q    <= rr_ptr;
                rsp_ovf_q   <= cap_ovf;
                rsp_valid_q <= 1'b1;
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_f     = alu_f_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
    assign bus.busy      = (state != S_IDLE);

`ifdef ALU_OVF_STICKY_EN
    logic [NREQ-1:0] sticky_q;
    logic [NREQ-1:0] sticky_set;

    // rr_ptr still names the owner at the capture edge.
    assign sticky_set = (capture_en && cap_ovf) ? (NREQ'(1) << rr_ptr) : '0;

    // Sticky overflow per requester; a set beats a same-cycle clear.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) sticky_q <= '0;
        else       sticky_q <= (sticky_q & ~bus.ovf_clr) | sticky_set;
    end

    assign bus.ovf_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler with a behavioural 3-bit signed ALU.
module tb_alu_rr_scheduler;
    localparam int NREQ  = 2;
    localparam int NBITS = 3;

    logic clk;
    logic rst;
    logic force_ovf;
    int   n_total;
    int   n_pass;

    typedef struct {
        int id;
        int y;
        int ovf;
    } exp_t;
    exp_t sb[$];

`ifdef ALU_OVF_STICKY_EN
    logic [NREQ-1:0] clr_in_exec;
`endif

    alu_rr_scheduler_if #(.NREQ(NREQ), .NBITS(NBITS)) bus ();

    alu_rr_scheduler #(.NREQ(NREQ), .NBITS(NBITS)) dut (
        .clk_2 (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: signed add/sub with overflow, AND/OR; force_ovf pins the flag high.
    always_comb begin
        logic [2:0] a, b, y;
        logic       v;
        a = bus.alu_a;
        b = bus.alu_b;
        y = '0;
        v = 1'b0;
        case (bus.alu_f)
            2'b00: begin y = a + b; v = (a[2] == b[2]) && (y[2] != a[2]); end
            2'b01: begin y = a - b; v = (a[2] != b[2]) && (y[2] != a[2]); end
            2'b10: y = a & b;
            default: y = a | b;
        endcase
        if (force_ovf) v = 1'b1;
        bus.alu_y   = y;
        bus.alu_ovf = v;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every response pops the oldest expectation.
    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rsp: rsp_valid=1 id=%0d y=%0d, none expected",
                         bus.rsp_id, bus.rsp_y);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id", int'(bus.rsp_id), e.id);
                check("rsp_y", int'(bus.rsp_y), e.y);
                check("rsp_ovf", int'(bus.rsp_ovf), e.ovf);
            end
        end
    end

    task automatic do_op(input int id, input logic [2:0] a, input logic [2:0] b,
                         input logic [1:0] f, input logic [2:0] ey, input logic eovf);
        int lat;
        @(negedge clk);
        bus.req_a[id*NBITS +: NBITS] = a;
        bus.req_b[id*NBITS +: NBITS] = b;
        bus.req_f[id*2 +: 2]         = f;
        bus.req[id]                  = 1'b1;
        sb.push_back('{id, int'(ey), int'(eovf)});
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.gnt == '0 && lat < 4);
        check("gnt_latency", lat, 1);
        check("gnt_onehot", int'(bus.gnt), 1 << id);
        check("alu_a", int'(bus.alu_a), int'(a));
        check("alu_f", int'(bus.alu_f), int'(f));
        check("busy_exec", int'(bus.busy), 1);
        bus.req[id] = 1'b0;
        bus.req_a[id*NBITS +: NBITS] = ~a;
        bus.req_f[id*2 +: 2]         = ~f;
`ifdef ALU_OVF_STICKY_EN
        bus.ovf_clr = clr_in_exec;
`endif
        @(negedge clk);
`ifdef ALU_OVF_STICKY_EN
        bus.ovf_clr = '0;
`endif
        check("alu_a_hold", int'(bus.alu_a), int'(a));
        check("gnt_drop", int'(bus.gnt), 0);
        check("busy_resp", int'(bus.busy), 1);
        @(negedge clk);
        check("rsp_valid_drop", int'(bus.rsp_valid), 0);
        check("rsp_y_hold", int'(bus.rsp_y), int'(ey));
        check("busy_idle", int'(bus.busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b1;
        force_ovf = 1'b0;
        bus.req   = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_f = '0;
`ifdef ALU_OVF_STICKY_EN
        bus.ovf_clr = '0;
        clr_in_exec = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_gnt", int'(bus.gnt), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("rst_alu_a", int'(bus.alu_a), 0);
        rst = 1'b0;

        // 3 + 1 overflows to -4; -2 - 1 = -3 without overflow.
        do_op(0, 3'b011, 3'b001, 2'b00, 3'b100, 1'b1);
        do_op(1, 3'b110, 3'b001, 2'b01, 3'b101, 1'b0);

        // Both requesting continuously: grants alternate every third cycle.
        @(negedge clk);
        bus.req_a = {3'b010, 3'b001};
        bus.req_b = {3'b011, 3'b001};
        bus.req_f = {2'b01, 2'b00};
        bus.req   = 2'b11;
        sb.push_back('{0, 2, 0});
        sb.push_back('{1, 7, 0});
        sb.push_back('{0, 2, 0});
        sb.push_back('{1, 7, 0});
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c % 3 == 1) check("rr_gnt", int'(bus.gnt), (((c - 1) / 3) % 2 == 0) ? 1 : 2);
            else            check("rr_gnt_idle", int'(bus.gnt), 0);
            check("rr_busy", int'(bus.busy), (c % 3 != 0) ? 1 : 0);
            if (c == 12) bus.req = '0;
        end

        // Logic ops mask a raised ALU overflow flag.
        force_ovf = 1'b1;
        do_op(0, 3'b110, 3'b011, 2'b10, 3'b010, 1'b0);
        do_op(0, 3'b110, 3'b011, 2'b11, 3'b111, 1'b0);
        force_ovf = 1'b0;

`ifdef ALU_OVF_STICKY_EN
        do_op(1, 3'b011, 3'b001, 2'b00, 3'b100, 1'b1);
        check("sticky_set", int'(bus.ovf_sticky), 2);
        repeat (2) @(negedge clk);
        check("sticky_hold", int'(bus.ovf_sticky), 2);
        bus.ovf_clr = 2'b10;
        @(negedge clk);
        bus.ovf_clr = '0;
        check("sticky_clr", int'(bus.ovf_sticky), 0);
        clr_in_exec = 2'b10;
        do_op(1, 3'b011, 3'b001, 2'b00, 3'b100, 1'b1);
        clr_in_exec = '0;
        check("sticky_set_wins", int'(bus.ovf_sticky), 2);
`endif

        // Reset in the middle of EXEC aborts the operation.
        @(negedge clk);
        bus.req_a[NBITS +: NBITS] = 3'b011;
        bus.req_b[NBITS +: NBITS] = 3'b011;
        bus.req_f[2 +: 2]         = 2'b00;
        bus.req                   = 2'b10;
        @(negedge clk);
        check("pre_rst_gnt", int'(bus.gnt), 2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_gnt", int'(bus.gnt), 0);
        check("mid_rst_alu_a", int'(bus.alu_a), 0);
        check("mid_rst_alu_b", int'(bus.alu_b), 0);
        check("mid_rst_rsp_y", int'(bus.rsp_y), 0);
        check("mid_rst_rsp_id", int'(bus.rsp_id), 0);
        check("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
`ifdef ALU_OVF_STICKY_EN
        check("mid_rst_sticky", int'(bus.ovf_sticky), 0);
`endif
        repeat (2) @(negedge clk);
        bus.req_a = {3'b011, 3'b001};
        bus.req_b = {3'b011, 3'b010};
        bus.req_f = {2'b00, 2'b01};
        bus.req   = 2'b11;
        sb.push_back('{0, 7, 0});
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_gnt", int'(bus.gnt), 1);
        bus.req = '0;
        repeat (3) @(negedge clk);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
